// File: rtl/lut_config_loader_if.sv
// Config-load bus for lut_config_loader: start pulse, word stream with parity, committed LUT image and status.
// The master drives the word stream; the slave (loader) returns ready, the committed image and status flags.
interface lut_config_loader_if #(
   parameter int INPUTS   = 4,
   parameter int NUM_LUTS = 8,
   parameter int WORD_W   = 8
);
   localparam int CFG_BITS = NUM_LUTS * (2 ** INPUTS);

   logic                start;
   logic [WORD_W-1:0]   cfg_word;
   logic                cfg_parity;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [CFG_BITS-1:0] cfg_bits;
   logic                busy;
   logic                done;
   logic                err;

   modport master (
      output start, cfg_word, cfg_parity, cfg_valid,
      input  cfg_ready, cfg_bits, busy, done, err
   );

   modport slave (
      input  start, cfg_word, cfg_parity, cfg_valid,
      output cfg_ready, cfg_bits, busy, done, err
   );
endinterface

// File: rtl/lut_config_loader.sv
// Streams WORD_W-bit words into a shadow image, then commits all LUT bits atomically one cycle after the last word.
// Optional macro CFG_PARITY_EN: even-parity check per word; a bad word aborts the load and sets sticky err.
module lut_config_loader #(
   parameter int INPUTS   = 4,
   parameter int NUM_LUTS = 8,
   parameter int WORD_W   = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   lut_config_loader_if.slave s_cfg
);
   localparam int CFG_BITS = NUM_LUTS * (2 ** INPUTS);
   localparam int WORDS    = CFG_BITS / WORD_W;
   localparam int CNT_W    = $clog2(WORDS + 1);

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [CFG_BITS-1:0] r_shadow;
   logic [CFG_BITS-1:0] r_cfg_bits;
   logic                r_cfg_ready;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   logic                w_accept;
   logic                w_last;
   logic                w_par_err;

   assign w_accept = s_cfg.cfg_valid && r_cfg_ready && (r_state == LOAD);
   assign w_last   = (r_cnt == CNT_W'(WORDS - 1));

`ifdef CFG_PARITY_EN
   assign w_par_err = ^{s_cfg.cfg_word, s_cfg.cfg_parity};
`else
   logic w_unused_parity;
   assign w_unused_parity = s_cfg.cfg_parity;
   assign w_par_err       = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_shadow    <= '0;
         r_cfg_bits  <= '0;
         r_cfg_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (s_cfg.start) begin
                  r_state     <= LOAD;
                  r_cnt       <= '0;
                  r_err       <= 1'b0;
                  r_cfg_ready <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            LOAD: begin
               if (w_accept) begin
                  // A corrupt word abandons the whole image; the committed bits stay untouched.
                  if (w_par_err) begin
                     r_state     <= IDLE;
                     r_err       <= 1'b1;
                     r_cfg_ready <= 1'b0;
                     r_busy      <= 1'b0;
                  end else begin
                     r_shadow[int'(r_cnt) * WORD_W +: WORD_W] <= s_cfg.cfg_word;
                     r_cnt <= r_cnt + 1'b1;
                     if (w_last) begin
                        r_state     <= COMMIT;
                        r_cfg_ready <= 1'b0;
                     end
                  end
               end
            end
            COMMIT: begin
               r_cfg_bits <= r_shadow;
               r_done     <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= IDLE;
            end
            default: begin
               r_state     <= IDLE;
               r_cfg_ready <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign s_cfg.cfg_ready = r_cfg_ready;
   assign s_cfg.cfg_bits  = r_cfg_bits;
   assign s_cfg.busy      = r_busy;
   assign s_cfg.done      = r_done;
   assign s_cfg.err       = r_err;
endmodule

// File: doc/lut_config_loader.md
LUT_CONFIG_LOADER -- requirements
Module: lut_config_loader

Interface
REQ-001 The module SHALL have parameter INPUTS, default 4, giving the LUT address width; each LUT holds 2^INPUTS config bits.
REQ-002 The module SHALL have parameter NUM_LUTS, default 8, giving the number of LUTs configured.
REQ-003 The module SHALL have parameter WORD_W, default 8, giving the config word width; CFG_BITS = NUM_LUTS*2^INPUTS SHALL be a multiple of WORD_W, and WORDS = CFG_BITS/WORD_W.
REQ-004 The module SHALL have clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have start, input, 1 bit: a pulse that begins a load sequence.
REQ-007 The module SHALL have cfg_word, input, WORD_W bits: the config data word.
REQ-008 The module SHALL have cfg_parity, input, 1 bit: the even-parity bit for cfg_word.
REQ-009 The module SHALL have cfg_valid, input, 1 bit: the upstream word-valid signal.
REQ-010 The module SHALL have cfg_ready, output, 1 bit: the loader's accept signal.
REQ-011 The module SHALL have cfg_bits, output, CFG_BITS bits: the committed LUT contents; LUT j occupies bits [j*2^INPUTS +: 2^INPUTS], and bit a of that slice is the LUT output for address a.
REQ-012 The module SHALL have busy, output, 1 bit: high while a sequence is in progress.
REQ-013 The module SHALL have done, output, 1 bit: a one-cycle pulse on commit.
REQ-014 The module SHALL have err, output, 1 bit: a sticky parity-error flag.

Function
REQ-015 The module SHALL implement an FSM with states IDLE, LOAD and COMMIT.
REQ-016 In IDLE, cfg_ready SHALL be 0 and busy SHALL be 0; start=1 SHALL move the FSM to LOAD, clear the word counter and clear err.
REQ-017 In LOAD, cfg_ready SHALL be 1 and busy SHALL be 1; a word is accepted on any edge where cfg_valid and cfg_ready are both 1.
REQ-018 Accepted word k (0..WORDS-1) SHALL be written to shadow[k*WORD_W +: WORD_W]; the counter SHALL increment by 1 per accept and SHALL never wrap within a sequence.
REQ-019 Acceptance of word WORDS-1 SHALL move the FSM to COMMIT; cfg_ready SHALL be 0 from the next cycle.
REQ-020 In COMMIT (busy=1), the next edge SHALL copy shadow to cfg_bits atomically, assert done for exactly one cycle, and return the FSM to IDLE; the new cfg_bits and done=1 SHALL become visible in the same cycle.
REQ-021 Latency SHALL be: last handshake at edge N, cfg_bits updated and done high after edge N+1, done low after edge N+2.
REQ-022 cfg_bits SHALL never change except at commit or reset; no partial update SHALL be visible.
REQ-023 start SHALL be ignored in LOAD and COMMIT.
REQ-024 cfg_valid SHALL be ignored in IDLE and COMMIT, including when it coincides with start.
REQ-025 A cfg_valid gap mid-LOAD SHALL hold the counter and shadow unchanged.

Reset
REQ-026 rst=1 at a clock edge SHALL set the FSM to IDLE, clear the counter, shadow and cfg_bits to 0, and drive cfg_ready, busy, done and err to 0.
REQ-027 Reset SHALL take priority over all other inputs; a reset mid-LOAD or mid-COMMIT SHALL discard the sequence with no commit.

Configuration
REQ-028 With macro CFG_PARITY_EN defined, an accepted word whose XOR of cfg_word and cfg_parity is 1 SHALL set err=1, return the FSM to IDLE with no commit and no done, and leave cfg_bits unchanged.
REQ-029 With CFG_PARITY_EN defined, err SHALL hold until the next start or rst.
REQ-030 Without CFG_PARITY_EN, cfg_parity SHALL be ignored and err SHALL be constant 0.

Verification
REQ-031 The bench SHALL cover: defaults, start, then 16 words 0x00..0x0F back-to-back -> done high exactly 1 cycle after the 16th handshake; cfg_bits = 0x0F0E..0100; LUT 0 slice = 0x0100.
REQ-032 The bench SHALL cover: cfg_valid toggled 1/0 every cycle during load -> exactly 16 accepts, identical cfg_bits, done 1 cycle after the last accept.
REQ-033 The bench SHALL cover: rst asserted after 7 words -> cfg_bits = 0, busy = 0, no done; a fresh full load then commits correctly.
REQ-034 The bench SHALL cover: start pulsed during LOAD, and cfg_valid held with start in IDLE -> no extra accept, counter unaffected.
REQ-035 The bench SHALL cover: with CFG_PARITY_EN, word 5 = 0x03 with cfg_parity=1 -> err=1, FSM in IDLE, previous cfg_bits retained, no done; the next start clears err.
REQ-036 The bench SHALL cover: two consecutive full loads with different data -> cfg_bits switches from the first image to the second only in the second done cycle.
